// File: rtl/decoration_controller_pkg.sv
// Shared definitions for the decoration opcode stream: opcode values,
// the category/colour/power enums and a small width helper.
package halloween_pkg;

  // System opcodes
  localparam logic [3:0] ON        = 4'b0000;
  localparam logic [3:0] RESET     = 4'b0001;
  // Colour opcodes
  localparam logic [3:0] GREEN     = 4'b0100;
  localparam logic [3:0] PURPLE    = 4'b0101;
  localparam logic [3:0] ORANGE    = 4'b0110;
  // Sound opcodes
  localparam logic [3:0] SCREAMING = 4'b1000;
  localparam logic [3:0] CACKLING  = 4'b1001;
  localparam logic [3:0] BOO       = 4'b1010;
  // Movement opcodes
  localparam logic [3:0] WAVEHANDS = 4'b1100;
  localparam logic [3:0] MOVEJAW   = 4'b1101;
  localparam logic [3:0] FOG       = 4'b1110;

  typedef enum logic [1:0] {
    CAT_SYSTEM = 2'b00,
    CAT_COLOUR = 2'b01,
    CAT_SOUND  = 2'b10,
    CAT_MOVE   = 2'b11
  } category_e;

  typedef enum logic [1:0] {
    COL_GREEN  = 2'b00,
    COL_PURPLE = 2'b01,
    COL_ORANGE = 2'b10,
    COL_DARK   = 2'b11
  } color_e;

  typedef enum logic {
    PWR_OFF = 1'b0,
    PWR_ON  = 1'b1
  } power_e;

  function automatic int unsigned maxOf(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/decoration_controller_effect_timer.sv
// Down-counting effect timer: load N, count down to zero and hold there.
// The effect is active whenever the count is nonzero, so a load produces
// exactly N active cycles and a reload on the last cycle leaves no gap.
module effect_timer #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic active
);

  logic [W-1:0] r_count;

  // Load takes precedence over decrement; the count never wraps below zero
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= W'(N);
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign active = (r_count != '0);

endmodule

// File: rtl/decoration_controller.sv
// Decoration controller: executes 4-bit opcodes from the sequencer,
// holding power/colour state and timing sound, movement and fog effects.
// Optional build macro HALLOWEEN_FOG_COOLDOWN_EN adds a dead period after
// fog expires during which further fog requests are ignored.
module decoration_controller
  import halloween_pkg::*;
#(
  parameter int unsigned SOUND_CYCLES = 8,
  parameter int unsigned MOVE_CYCLES  = 4,
  parameter int unsigned FOG_CYCLES   = 16,
  parameter int unsigned FOG_COOLDOWN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       opcode_valid,
  output logic       powered,
  output logic [1:0] color,
  output logic       sound_active,
  output logic [1:0] sound_sel,
  output logic       wave_hands,
  output logic       move_jaw,
  output logic       fog,
  output logic       illegal
);

  localparam int unsigned TIMER_MAX = maxOf(maxOf(SOUND_CYCLES, MOVE_CYCLES),
                                            maxOf(FOG_CYCLES, FOG_COOLDOWN));
  localparam int unsigned TIMER_W   = (TIMER_MAX == 0) ? 1 : $clog2(TIMER_MAX + 1);

  power_e     r_state;
  logic       r_powered;
  color_e     r_color;
  logic [1:0] r_soundSel;
  logic       r_illegal;

  category_e  w_category;
  logic       w_acceptOn;
  logic       w_resetCmd;
  logic       w_colorLoad;
  logic       w_soundLoad;
  logic       w_waveLoad;
  logic       w_jawLoad;
  logic       w_fogReq;
  logic       w_fogLoad;
  logic       w_illegal;
  logic       w_timerRst;
  logic       w_fogActive;

  // Decode the sampled opcode against the current power state
  always_comb begin
    w_category  = category_e'(opcode[3:2]);
    w_acceptOn  = 1'b0;
    w_resetCmd  = 1'b0;
    w_colorLoad = 1'b0;
    w_soundLoad = 1'b0;
    w_waveLoad  = 1'b0;
    w_jawLoad   = 1'b0;
    w_fogReq    = 1'b0;
    w_illegal   = 1'b0;
    if (opcode_valid) begin
      if (r_state == PWR_OFF) begin
        w_acceptOn = (opcode == ON);
      end else begin
        unique case (w_category)
          CAT_SYSTEM: begin
            w_resetCmd = (opcode == RESET);
            w_illegal  = (opcode[1] == 1'b1);
          end
          CAT_COLOUR: begin
            w_colorLoad = (opcode[1:0] != 2'b11);
            w_illegal   = (opcode[1:0] == 2'b11);
          end
          CAT_SOUND: begin
            w_soundLoad = (opcode[1:0] != 2'b11);
            w_illegal   = (opcode[1:0] == 2'b11);
          end
          CAT_MOVE: begin
            w_waveLoad = (opcode == WAVEHANDS);
            w_jawLoad  = (opcode == MOVEJAW);
            w_fogReq   = (opcode == FOG);
            w_illegal  = (opcode[1:0] == 2'b11);
          end
          default: ;
        endcase
      end
    end
  end

  assign w_timerRst = rst | w_resetCmd;

`ifdef HALLOWEEN_FOG_COOLDOWN_EN
  localparam int unsigned COOL_LOAD = (FOG_COOLDOWN > 0) ? FOG_COOLDOWN - 1 : 0;

  logic r_fogPrev;
  logic w_fogFall;
  logic w_coolActive;

  // Remember last cycle's fog so its expiry can start the cooldown
  always_ff @(posedge clk) begin
    if (w_timerRst) begin
      r_fogPrev <= 1'b0;
    end else begin
      r_fogPrev <= w_fogActive;
    end
  end

  // The first low cycle after fog counts as cooldown, the timer covers the rest
  assign w_fogFall = r_fogPrev & ~w_fogActive & (FOG_COOLDOWN > 0);
  assign w_fogLoad = w_fogReq & ~(w_fogFall | w_coolActive);

  effect_timer #(.N(COOL_LOAD), .W(TIMER_W)) u_coolTimer (
    .clk    (clk),
    .rst    (w_timerRst),
    .load   (w_fogFall),
    .active (w_coolActive)
  );
`else
  assign w_fogLoad = w_fogReq;
`endif

  // Power FSM with registered power, colour, sound selection and illegal pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= PWR_OFF;
      r_powered  <= 1'b0;
      r_color    <= COL_DARK;
      r_soundSel <= 2'b00;
      r_illegal  <= 1'b0;
    end else begin
      r_illegal <= w_illegal;
      if (w_acceptOn) begin
        r_state   <= PWR_ON;
        r_powered <= 1'b1;
        r_color   <= COL_GREEN;
      end
      if (w_resetCmd) begin
        r_state   <= PWR_OFF;
        r_powered <= 1'b0;
        r_color   <= COL_DARK;
      end
      if (w_colorLoad) begin
        r_color <= color_e'(opcode[1:0]);
      end
      if (w_soundLoad) begin
        r_soundSel <= opcode[1:0];
      end
    end
  end

  effect_timer #(.N(SOUND_CYCLES), .W(TIMER_W)) u_soundTimer (
    .clk    (clk),
    .rst    (w_timerRst),
    .load   (w_soundLoad),
    .active (sound_active)
  );

  effect_timer #(.N(MOVE_CYCLES), .W(TIMER_W)) u_waveTimer (
    .clk    (clk),
    .rst    (w_timerRst),
    .load   (w_waveLoad),
    .active (wave_hands)
  );

  effect_timer #(.N(MOVE_CYCLES), .W(TIMER_W)) u_jawTimer (
    .clk    (clk),
    .rst    (w_timerRst),
    .load   (w_jawLoad),
    .active (move_jaw)
  );

  effect_timer #(.N(FOG_CYCLES), .W(TIMER_W)) u_fogTimer (
    .clk    (clk),
    .rst    (w_timerRst),
    .load   (w_fogLoad),
    .active (w_fogActive)
  );

  assign fog       = w_fogActive;
  assign powered   = r_powered;
  assign color     = r_color;
  assign sound_sel = r_soundSel;
  assign illegal   = r_illegal;

endmodule
